// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: funct3 encodings,
// FSM states and access-size decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_D    = 3'b011;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;
    localparam logic [2:0] F3_WU   = 3'b110;
    localparam logic [2:0] F3_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        return 8'((9'd1 << size_bytes(sz)) - 9'd1);
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] f3, input int xlen);
        return (f3 == F3_RSVD) || (we && f3[2]) ||
               ((xlen == 32) && ((f3 == F3_D) || (f3 == F3_WU)));
    endfunction

endpackage

// File: rtl/lsu_align_load_ext.sv
// Sign/zero extension of an LSB-justified load value to the full datapath width.
module load_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] ext_o
);

    logic [6:0] nbits;
    logic       sign;

    always_comb begin
        nbits = 7'd8 << size_i;
        case (size_i)
            2'd0:    sign = raw_i[7];
            2'd1:    sign = raw_i[15];
            2'd2:    sign = raw_i[31];
            default: sign = raw_i[XLEN-1];
        endcase
        for (int i = 0; i < XLEN; i++) begin
            ext_o[i] = (i < int'(nbits)) ? raw_i[i] : (sign & ~unsigned_i);
        end
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: turns byte-addressed RISC-V accesses into
// line-aligned memory beats, splitting line-crossing accesses into two beats.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MISALIGN_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the sender holds its payload stable while valid && !ready.
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int WB   = 2 * NB;

    lsu_state_e state_q, state_d;

    logic              we_q;
    logic [2:0]        f3_q;
    logic [OFFW-1:0]   off_q;
    logic [XLEN-1:0]   line_q;
    logic              cross_q;
    logic              err_q;
    logic [2*XLEN-1:0] wide_q;
    logic [WB-1:0]     mask_q;
    logic [2*XLEN-1:0] rbuf_q;

    logic [OFFW-1:0]   req_off;
    logic [4:0]        req_end;
    logic              req_cross;
    logic              req_bad;
    logic [2*XLEN-1:0] req_wide;
    logic [WB-1:0]     req_mask;
    logic              accept;
    logic [XLEN-1:0]   load_raw;
    logic [XLEN-1:0]   load_ext_val;

    assign req_off   = req_addr[OFFW-1:0];
    assign req_end   = 5'(req_off) + 5'(size_bytes(req_funct3[1:0]));
    assign req_cross = req_end > 5'(NB);
    assign req_bad   = is_illegal(req_we, req_funct3, XLEN) || (req_cross && (MISALIGN_EN == 0));
    assign req_wide  = {{XLEN{1'b0}}, req_wdata} << {req_off, 3'b000};
    assign req_mask  = WB'(size_mask(req_funct3[1:0])) << req_off;
    assign accept    = req_valid && (state_q == ST_IDLE);
    assign dbg_state = state_q;

    // Both beats land in a double-width buffer at their own lanes, so shifting
    // right by the offset yields the access bytes LSB-first.
    assign load_raw = XLEN'(rbuf_q >> {off_q, 3'b000});

    load_ext #(.XLEN(XLEN)) u_load_ext (
        .raw_i      (load_raw),
        .size_i     (f3_q[1:0]),
        .unsigned_i (f3_q[2]),
        .ext_o      (load_ext_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= '0;
            line_q  <= '0;
            cross_q <= 1'b0;
            err_q   <= 1'b0;
            wide_q  <= '0;
            mask_q  <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                off_q   <= req_off;
                line_q  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                cross_q <= req_cross;
                err_q   <= req_bad;
                wide_q  <= req_wide;
                mask_q  <= req_mask;
            end
            if ((state_q == ST_BEAT0) && mem_ready) begin
                rbuf_q[XLEN-1:0] <= mem_rdata;
            end
            if ((state_q == ST_BEAT1) && mem_ready) begin
                rbuf_q[2*XLEN-1:XLEN] <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wstrb  = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_bad ? ST_RESP : ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                mem_valid = 1'b1;
                mem_we    = we_q;
                mem_addr  = line_q;
                if (we_q) begin
                    mem_wstrb = mask_q[NB-1:0];
                    mem_wdata = wide_q[XLEN-1:0];
                end
                if (mem_ready) begin
                    state_d = cross_q ? ST_BEAT1 : ST_RESP;
                end
            end
            ST_BEAT1: begin
                mem_valid = 1'b1;
                mem_we    = we_q;
                mem_addr  = line_q + XLEN'(NB);
                if (we_q) begin
                    mem_wstrb = mask_q[WB-1:NB];
                    mem_wdata = wide_q[2*XLEN-1:XLEN];
                end
                if (mem_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || we_q) ? '0 : load_ext_val;
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align: a 32-bit splitting instance checked through
// beat/response scoreboards, plus a rejecting 32-bit and a 64-bit instance.
module tb_lsu_align;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- instance A: XLEN=32, MISALIGN_EN=1 ----------------
    logic        a_req_valid, a_req_ready, a_req_we;
    logic [2:0]  a_req_funct3;
    logic [31:0] a_req_addr, a_req_wdata;
    logic        a_mem_valid, a_mem_ready, a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_wstrb;
    logic        a_resp_valid, a_resp_ready, a_resp_err;
    logic [31:0] a_resp_rdata;
    logic [1:0]  a_dbg;

    lsu_align #(.XLEN(32), .MISALIGN_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .mem_valid(a_mem_valid), .mem_ready(a_mem_ready), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wstrb(a_mem_wstrb), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .dbg_state(a_dbg)
    );

    // ---------------- instance B: XLEN=32, MISALIGN_EN=0 ----------------
    logic        b_req_valid, b_req_ready, b_req_we;
    logic [2:0]  b_req_funct3;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_mem_valid, b_mem_we;
    logic        b_mem_ready = 1'b1;
    logic [31:0] b_mem_addr, b_mem_wdata;
    logic [31:0] b_mem_rdata = 32'hCAFE_F00D;
    logic [3:0]  b_mem_wstrb;
    logic        b_resp_valid, b_resp_err;
    logic        b_resp_ready = 1'b1;
    logic [31:0] b_resp_rdata;
    logic [1:0]  b_dbg;

    lsu_align #(.XLEN(32), .MISALIGN_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .mem_valid(b_mem_valid), .mem_ready(b_mem_ready), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wstrb(b_mem_wstrb), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .dbg_state(b_dbg)
    );

    // ---------------- instance C: XLEN=64, MISALIGN_EN=1 ----------------
    logic        c_req_valid, c_req_ready, c_req_we;
    logic [2:0]  c_req_funct3;
    logic [63:0] c_req_addr, c_req_wdata;
    logic        c_mem_valid, c_mem_we;
    logic        c_mem_ready = 1'b1;
    logic [63:0] c_mem_addr, c_mem_wdata;
    logic [63:0] c_mem_rdata = 64'h8877_6655_4433_2211;
    logic [7:0]  c_mem_wstrb;
    logic        c_resp_valid, c_resp_err;
    logic        c_resp_ready = 1'b1;
    logic [63:0] c_resp_rdata;
    logic [1:0]  c_dbg;

    lsu_align #(.XLEN(64), .MISALIGN_EN(1)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .req_valid(c_req_valid), .req_ready(c_req_ready), .req_we(c_req_we),
        .req_funct3(c_req_funct3), .req_addr(c_req_addr), .req_wdata(c_req_wdata),
        .mem_valid(c_mem_valid), .mem_ready(c_mem_ready), .mem_we(c_mem_we),
        .mem_addr(c_mem_addr), .mem_wstrb(c_mem_wstrb), .mem_wdata(c_mem_wdata),
        .mem_rdata(c_mem_rdata), .resp_valid(c_resp_valid), .resp_ready(c_resp_ready),
        .resp_rdata(c_resp_rdata), .resp_err(c_resp_err), .dbg_state(c_dbg)
    );

    // ---------------- scoreboard for A ----------------
    logic [68:0] exp_beat_q[$];   // {we, wstrb, wdata, addr}
    logic [32:0] exp_resp_q[$];   // {err, rdata}
    logic [31:0] rd_q[$];
    logic [68:0] e_beat;
    logic [32:0] e_resp;
    int          rd_pop_req  = 0;
    int          rd_pop_done = 0;
    int          b_beats = 0;
    logic [63:0] c_addr_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] addr, input logic we,
                             input logic [3:0] strb, input logic [31:0] wdata);
        exp_beat_q.push_back({we, strb, wdata, addr});
    endtask

    task automatic push_resp(input logic err, input logic [31:0] rdata);
        exp_resp_q.push_back({err, rdata});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_mem_valid && a_mem_ready) begin
                if (exp_beat_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got addr 0x%0h expected no beat", a_mem_addr);
                end else begin
                    e_beat = exp_beat_q.pop_front();
                    check("beat_addr", 64'(a_mem_addr), 64'(e_beat[31:0]));
                    check("beat_we", 64'(a_mem_we), 64'(e_beat[68]));
                    if (e_beat[68]) begin
                        check("beat_wstrb", 64'(a_mem_wstrb), 64'(e_beat[67:64]));
                        check("beat_wdata", 64'(a_mem_wdata), 64'(e_beat[63:32]));
                    end
                end
                if (!a_mem_we) rd_pop_req++;
            end
            if (a_resp_valid && a_resp_ready) begin
                if (exp_resp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got rdata 0x%0h expected no response", a_resp_rdata);
                end else begin
                    e_resp = exp_resp_q.pop_front();
                    check("resp_err", 64'(a_resp_err), 64'(e_resp[32]));
                    check("resp_rdata", 64'(a_resp_rdata), 64'(e_resp[31:0]));
                end
            end
        end
    end

    // Memory read data for A changes only just after a clock edge.
    always @(posedge clk) begin
        #1;
        if (rd_pop_done != rd_pop_req) begin
            rd_pop_done = rd_pop_req;
            if (rd_q.size() > 0) void'(rd_q.pop_front());
        end
        a_mem_rdata = (rd_q.size() > 0) ? rd_q[0] : 32'h0;
    end

    always @(negedge clk) begin
        if (b_mem_valid) b_beats++;
        if (c_mem_valid && c_mem_ready) c_addr_q.push_back(c_mem_addr);
    end

    // ---------------- drivers ----------------
    task automatic a_issue(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = we; a_req_funct3 = f3;
        a_req_addr = addr; a_req_wdata = wdata;
        while (!a_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!a_req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no req_ready within %0d cycles", n);
            a_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Scramble the request bus after accept; the unit must use its copy.
        a_req_valid = 1'b0; a_req_we = ~we; a_req_funct3 = 3'b111;
        a_req_addr = ~addr; a_req_wdata = ~wdata;
    endtask

    task automatic a_wait_idle(input string name, input int exp_lat);
        int lat;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            if (a_req_ready) break;
            @(posedge clk);
            lat++;
        end
        if (lat >= 100) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no return to idle expected within 100 cycles", name);
        end else if (exp_lat >= 0) begin
            check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        end
        check({name, "_drained"}, 64'(exp_beat_q.size() + exp_resp_q.size()), 64'd0);
    endtask

    task automatic b_run(input logic [2:0] f3, input logic [31:0] addr,
                         output logic [31:0] rdata, output logic err);
        int n;
        n = 0;
        rdata = 32'hx; err = 1'bx;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_funct3 = f3; b_req_addr = addr;
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        while (n < 50) begin
            @(negedge clk);
            if (b_resp_valid) break;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL b_resp_timeout: got no resp_valid expected within 50 cycles");
        end else begin
            rdata = b_resp_rdata; err = b_resp_err;
        end
    endtask

    task automatic c_run(input logic [2:0] f3, input logic [63:0] addr,
                         output logic [63:0] rdata, output logic err);
        int n;
        n = 0;
        rdata = 64'hx; err = 1'bx;
        @(negedge clk);
        c_req_valid = 1'b1; c_req_we = 1'b0; c_req_funct3 = f3; c_req_addr = addr;
        @(posedge clk);
        #1;
        c_req_valid = 1'b0;
        while (n < 50) begin
            @(negedge clk);
            if (c_resp_valid) break;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL c_resp_timeout: got no resp_valid expected within 50 cycles");
        end else begin
            rdata = c_resp_rdata; err = c_resp_err;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] r32;
        logic [63:0] r64;
        logic        er;
        int          nb;

        rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_funct3 = 3'b0; a_req_addr = '0; a_req_wdata = '0;
        a_mem_ready = 1'b1; a_resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = 3'b0; b_req_addr = '0; b_req_wdata = '0;
        c_req_valid = 1'b0; c_req_we = 1'b0; c_req_funct3 = 3'b0; c_req_addr = '0; c_req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(a_req_ready), 64'd1);
        check("rst_mem_valid", 64'(a_mem_valid), 64'd0);
        check("rst_mem_we", 64'(a_mem_we), 64'd0);
        check("rst_mem_wstrb", 64'(a_mem_wstrb), 64'd0);
        check("rst_mem_addr", 64'(a_mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(a_mem_wdata), 64'd0);
        check("rst_resp_valid", 64'(a_resp_valid), 64'd0);
        check("rst_resp_err", 64'(a_resp_err), 64'd0);
        check("rst_resp_rdata", 64'(a_resp_rdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LB from top byte, sign-extended
        rd_q.push_back(32'h8000_0000);
        push_beat(32'h100, 1'b0, 4'h0, 32'h0); push_resp(1'b0, 32'hFFFF_FF80);
        a_issue(1'b0, 3'b000, 32'h103, 32'h0);
        a_wait_idle("lb_103", 2);

        // LB positive
        rd_q.push_back(32'h1234_567F);
        push_beat(32'h100, 1'b0, 4'h0, 32'h0); push_resp(1'b0, 32'h0000_007F);
        a_issue(1'b0, 3'b000, 32'h100, 32'h0);
        a_wait_idle("lb_100", 2);

        // LW crossing a line
        rd_q.push_back(32'hAABB_CCDD); rd_q.push_back(32'h1122_3344);
        push_beat(32'h100, 1'b0, 4'h0, 32'h0); push_beat(32'h104, 1'b0, 4'h0, 32'h0);
        push_resp(1'b0, 32'h3344_AABB);
        a_issue(1'b0, 3'b010, 32'h102, 32'h0);
        a_wait_idle("lw_102", 3);

        // SW crossing a line
        push_beat(32'h100, 1'b1, 4'b1000, 32'hEF00_0000);
        push_beat(32'h104, 1'b1, 4'b0111, 32'h00DE_ADBE);
        push_resp(1'b0, 32'h0);
        a_issue(1'b1, 3'b010, 32'h103, 32'hDEAD_BEEF);
        a_wait_idle("sw_103", 3);

        // LHU / LH at upper half
        rd_q.push_back(32'h8001_7777);
        push_beat(32'h200, 1'b0, 4'h0, 32'h0); push_resp(1'b0, 32'h0000_8001);
        a_issue(1'b0, 3'b101, 32'h202, 32'h0);
        a_wait_idle("lhu_202", 2);
        rd_q.push_back(32'h8001_7777);
        push_beat(32'h200, 1'b0, 4'h0, 32'h0); push_resp(1'b0, 32'hFFFF_8001);
        a_issue(1'b0, 3'b001, 32'h202, 32'h0);
        a_wait_idle("lh_202", 2);

        // SB to lane 1, SH crossing
        push_beat(32'h300, 1'b1, 4'b0010, 32'h0000_A500); push_resp(1'b0, 32'h0);
        a_issue(1'b1, 3'b000, 32'h301, 32'h0000_00A5);
        a_wait_idle("sb_301", 2);
        push_beat(32'h400, 1'b1, 4'b1000, 32'hEF00_0000);
        push_beat(32'h404, 1'b1, 4'b0001, 32'h0000_00BE);
        push_resp(1'b0, 32'h0);
        a_issue(1'b1, 3'b001, 32'h403, 32'h0000_BEEF);
        a_wait_idle("sh_403", 3);

        // Illegal encodings: no beat, error response
        push_resp(1'b1, 32'h0);
        a_issue(1'b0, 3'b011, 32'h000, 32'h0);
        a_wait_idle("ld_illegal", 1);
        push_resp(1'b1, 32'h0);
        a_issue(1'b0, 3'b111, 32'h010, 32'h0);
        a_wait_idle("f3_111", 1);
        push_resp(1'b1, 32'h0);
        a_issue(1'b1, 3'b100, 32'h020, 32'h55);
        a_wait_idle("sbu_illegal", 1);
        push_resp(1'b1, 32'h0);
        a_issue(1'b0, 3'b110, 32'h030, 32'h0);
        a_wait_idle("lwu_rv32", 1);

        // Memory stall: beat payload must hold
        a_mem_ready = 1'b0;
        rd_q.push_back(32'h1234_5678);
        push_beat(32'h500, 1'b0, 4'h0, 32'h0); push_resp(1'b0, 32'h1234_5678);
        a_issue(1'b0, 3'b010, 32'h500, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(a_mem_valid), 64'd1);
            check("stall_addr", 64'(a_mem_addr), 64'h500);
        end
        a_mem_ready = 1'b1;
        a_wait_idle("lw_stall", -1);

        // Response back-pressure: response held until resp_ready
        a_resp_ready = 1'b0;
        rd_q.push_back(32'h0000_00F0);
        push_beat(32'h600, 1'b0, 4'h0, 32'h0); push_resp(1'b0, 32'h0000_00F0);
        a_issue(1'b0, 3'b100, 32'h600, 32'h0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_resp_valid", 64'(a_resp_valid), 64'd1);
            check("hold_resp_rdata", 64'(a_resp_rdata), 64'h0000_00F0);
            check("hold_req_ready", 64'(a_req_ready), 64'd0);
        end
        a_resp_ready = 1'b1;
        a_wait_idle("lbu_hold", -1);

        // Rejecting instance
        nb = b_beats;
        b_run(3'b001, 32'h1FF, r32, er);
        check("b_lh_1ff_err", 64'(er), 64'd1);
        check("b_lh_1ff_rdata", 64'(r32), 64'd0);
        check("b_lh_1ff_beats", 64'(b_beats - nb), 64'd0);
        nb = b_beats;
        b_run(3'b010, 32'h104, r32, er);
        check("b_lw_104_err", 64'(er), 64'd0);
        check("b_lw_104_rdata", 64'(r32), 64'hCAFE_F00D);
        check("b_lw_104_beats", 64'(b_beats - nb), 64'd1);

        // 64-bit instance: crossing wraps the top of the address space
        c_addr_q.delete();
        c_run(3'b110, 64'hFFFF_FFFF_FFFF_FFFE, r64, er);
        check("c_lwu_err", 64'(er), 64'd0);
        check("c_lwu_rdata", r64, 64'h0000_0000_2211_8877);
        check("c_lwu_nbeats", 64'(c_addr_q.size()), 64'd2);
        if (c_addr_q.size() == 2) begin
            check("c_lwu_beat0_addr", c_addr_q[0], 64'hFFFF_FFFF_FFFF_FFF8);
            check("c_lwu_beat1_addr", c_addr_q[1], 64'h0);
        end
        c_run(3'b011, 64'h10, r64, er);
        check("c_ld_err", 64'(er), 64'd0);
        check("c_ld_rdata", r64, 64'h8877_6655_4433_2211);

        // Reset during a stalled first beat aborts silently
        a_mem_ready = 1'b0;
        a_issue(1'b0, 3'b010, 32'h700, 32'h0);
        repeat (5) @(negedge clk);
        check("abort_pre_valid", 64'(a_mem_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_valid", 64'(a_mem_valid), 64'd0);
        check("abort_req_ready", 64'(a_req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        a_mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_resp", 64'(a_resp_valid), 64'd0);
        end

        // Reset while the second store beat is pending: it must never issue
        a_mem_ready = 1'b0;
        push_beat(32'h900, 1'b1, 4'b1000, 32'h4400_0000);
        a_issue(1'b1, 3'b010, 32'h903, 32'h1122_3344);
        a_mem_ready = 1'b1;
        @(posedge clk);
        #1;
        a_mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("pend_beat1_addr", 64'(a_mem_addr), 64'h904);
        #2 rst_n = 1'b0;
        #1;
        check("pend_mem_valid", 64'(a_mem_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("pend_drained", 64'(exp_beat_q.size()), 64'd0);

        // Normal service after reset
        rd_q.push_back(32'h0BAD_F00D);
        push_beat(32'h800, 1'b0, 4'h0, 32'h0); push_resp(1'b0, 32'h0BAD_F00D);
        a_issue(1'b0, 3'b010, 32'h800, 32'h0);
        a_wait_idle("lw_after_rst", 2);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_align.md
LSU_ALIGN -- requirements
Module: lsu_align

Interface
REQ-001 Parameter XLEN, default 32, datapath and address width; legal values 32, 64.
REQ-002 Parameter MISALIGN_EN, default 1; 1 = split line-crossing accesses into two beats, 0 = reject them with an error.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  access request present.
REQ-006 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  RISC-V load/store funct3 (size, signedness).
REQ-009 req_addr  in  XLEN  byte address.
REQ-010 req_wdata  in  XLEN  store data, LSB-justified.
REQ-011 mem_valid / mem_ready  out / in  1  memory beat handshake; beat completes when both high.
REQ-012 mem_we  out  1; mem_addr  out  XLEN, always line-aligned (low log2(XLEN/8) bits zero).
REQ-013 mem_wstrb  out  XLEN/8; mem_wdata  out  XLEN; mem_rdata  in  XLEN, valid in the completing cycle of a read beat.
REQ-014 resp_valid / resp_ready  out / in  1  response handshake.
REQ-015 resp_rdata  out  XLEN  extended load result, zero for stores; resp_err  out  1  illegal or rejected access.

Function
REQ-016 Sizes: funct3[1:0] 00=1 B, 01=2 B, 10=4 B, 11=8 B; funct3[2]=1 zero-extends, 0 sign-extends.
REQ-017 Illegal: 8 B or funct3=110 when XLEN=32; funct3=111 always; any store with funct3[2]=1. Illegal requests issue no beat and give resp_err=1, resp_rdata=0.
REQ-018 Offset off = req_addr mod (XLEN/8); access is crossing when off+size > XLEN/8.
REQ-019 Crossing with MISALIGN_EN=0: no beat; resp_err=1.
REQ-020 FSM states IDLE, BEAT0, BEAT1, RESP; req_ready=1 only in IDLE.
REQ-021 IDLE -> BEAT0 on accept of a legal request; IDLE -> RESP on accept of an illegal or rejected request.
REQ-022 BEAT0: mem_addr = aligned address; on completion -> BEAT1 if crossing, else RESP.
REQ-023 BEAT1: mem_addr = aligned address + XLEN/8, wrapping modulo 2^XLEN; on completion -> RESP.
REQ-024 mem_valid is high in BEAT0/BEAT1 only; mem_addr/we/wstrb/wdata are stable while mem_valid && !mem_ready.
REQ-025 Store beats: BEAT0 wdata = req_wdata << 8*off with strobes for bytes off..min(off+size,XLEN/8)-1; BEAT1 carries remaining bytes at lanes 0.. with matching strobes.
REQ-026 Load: bytes captured from each beat at the same lanes, assembled LSB-first, then extended per REQ-016.
REQ-027 RESP: resp_valid=1, outputs held until resp_ready; RESP -> IDLE on handshake; no back-to-back accept in that cycle.
REQ-028 Latency: aligned access with mem_ready=1 and resp_ready=1 takes 3 cycles accept-to-IDLE (accept, beat, response); crossing adds 1.
REQ-029 Request fields are registered at accept; later changes to req_* have no effect.

Reset
REQ-030 rst_n low forces IDLE asynchronously; req_ready=1, mem_valid=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_err=0, resp_rdata=0.
REQ-031 Reset mid-access aborts it with no response; a pending second store beat is not issued.

Structure
REQ-032 Package lsu_pkg holds funct3 encodings, the FSM state enum, and the size-decode function.
REQ-033 One sub-module, load_ext: combinational extension of assembled bytes by size/signedness, parametrised by XLEN.

Verification
REQ-034 XLEN=32, LB addr 0x103, mem_rdata 0x80_00_00_00 -> one beat at 0x100, resp_rdata 0xFFFFFF80, resp_err=0.
REQ-035 XLEN=32, LW addr 0x102, beats return 0xAABB_CCDD then 0x1122_3344 -> beats at 0x100 and 0x104, resp_rdata 0x3344AABB.
REQ-036 XLEN=32, SW 0xDEADBEEF to 0x103 -> beat0 wstrb 1000 wdata 0xEF000000; beat1 addr 0x104 wstrb 0111 wdata 0x00DEADBE.
REQ-037 MISALIGN_EN=0, LH addr 0x1FF -> no mem_valid, resp_err=1; XLEN=64, LWU addr 0xFFFF_FFFF_FFFF_FFFE with MISALIGN_EN=1 -> beat1 addr 0x0.
REQ-038 mem_ready held low 5 cycles during BEAT0, then rst_n pulsed -> mem_valid drops immediately, no resp_valid, next request served normally.
